bf16_add_sched: RTL and testbench
=================================

# bf16_add_sched

Round-robin scheduler that shares one BF16 adder instance (SIZE_DATA-bit, sign/8-bit exponent/7-bit mantissa) among NUM_REQ requesters. It arbitrates among pending operand pairs and drives the adder's operand inputs from registers. It waits a configurable adder latency, captures the sum, and returns it with the requester ID over a valid/ready response channel. It sits between the sort-network compute clients and the single shared BF16 add datapath.

## Interface
- NUM_REQ, 4, number of requesters (>=2)
- SIZE_DATA, 16, BF16 word width
- ADD_LAT, 0, adder latency in cycles from operand register update to valid i_add_result (0 = combinational adder)
- ID_W, $clog2(NUM_REQ), response ID width
- i_clk  in  1  single clock; all state updates on rising edge
- i_rst_n  in  1  asynchronous active-low reset; clears all state immediately
- i_req_valid  in  NUM_REQ  per-requester operand pair valid
- i_req_a  in  NUM_REQ*SIZE_DATA  operand A, requester k at [k*SIZE_DATA +: SIZE_DATA]
- i_req_b  in  NUM_REQ*SIZE_DATA  operand B, same packing
- o_req_ready  out  NUM_REQ  one-hot grant/accept strobe
- o_add_a  out  SIZE_DATA  registered operand A to shared adder
- o_add_b  out  SIZE_DATA  registered operand B to shared adder
- i_add_result  in  SIZE_DATA  adder sum
- o_rsp_valid  out  1  response valid
- o_rsp_data  out  SIZE_DATA  captured sum
- o_rsp_id  out  ID_W  index of requester that issued the operation
- i_rsp_ready  in  1  response consumer ready
- o_busy  out  1  high whenever state != IDLE

## Operation
- FSM states: IDLE, WAIT, RESP. Reset state IDLE.
- IDLE: combinational round-robin search over i_req_valid starting at ptr+1 mod NUM_REQ. The first valid index g gets o_req_ready[g]=1. All other ready bits are 0. If no request is valid, all ready bits are 0.
- Acceptance = i_req_valid[g] & o_req_ready[g] at a rising edge. At that edge:
  - o_add_a/o_add_b <- requester g operands
  - o_rsp_id <- g
  - ptr <- g
  - cnt <- 0
  - state -> WAIT
- o_req_ready is 0 in WAIT and RESP; only one operation is in flight at a time.
- WAIT: each edge, if cnt == ADD_LAT then o_rsp_data <- i_add_result, o_rsp_valid <- 1, state -> RESP; else cnt <- cnt+1. cnt width is $clog2(ADD_LAT+1), minimum 1 bit.
- RESP: o_rsp_valid, o_rsp_data, o_rsp_id held stable until i_rsp_ready=1 at an edge. Then o_rsp_valid <- 0 and state -> IDLE. No same-cycle re-grant from RESP.
- o_add_a/o_add_b hold their value after the operation completes (changed only on acceptance).
- Requesters may deassert valid before being granted; arbitration re-evaluates every IDLE cycle. Once accepted, a requester's request is consumed, and it must present a new valid to issue again.
- Fairness: after serving g, g has lowest priority at the next arbitration. With all NUM_REQ requesting continuously, grants cycle 0,1,2,...,NUM_REQ-1,0,...
- The block does no arithmetic on the data. Exceptional BF16 values pass through the adder unchanged in handling.

## Timing
- Reset values (asynchronous, while i_rst_n=0):
  - state IDLE, ptr NUM_REQ-1 (requester 0 has first priority), cnt 0
  - o_add_a 0, o_add_b 0, o_rsp_valid 0, o_rsp_data 0, o_rsp_id 0, o_busy 0
  - o_req_ready 0 (forced while in reset)
- Latency: acceptance at edge E0 gives o_rsp_valid high after edge E0+ADD_LAT+1.
- Minimum issue interval is ADD_LAT+3 cycles: accept, ADD_LAT+1 WAIT edges, one RESP edge with i_rsp_ready=1, then re-arbitration in IDLE.
- i_add_result is sampled exactly once, at the edge ending the final WAIT cycle.
- Simultaneous valids: exactly one is granted; never more than one bit of o_req_ready is high.
- Reset mid-operation (WAIT or RESP): the in-flight op is discarded, no response is emitted, and the accepted requester is not re-served.
- i_rsp_ready held low indefinitely: the block stalls in RESP, o_busy stays 1, and no new grants are issued.

## Test plan
- Single op, ADD_LAT=0: req0 a=0x3F80 (1.0), b=0x4000 (2.0). Expect o_req_ready[0] same cycle, o_add_a=0x3F80 after the edge, o_rsp_valid one edge later with o_rsp_data=0x4040, o_rsp_id=0.
- Round-robin: all 4 valid continuously, i_rsp_ready=1. Expect o_rsp_id sequence 0,1,2,3,0, one response every 3 cycles.
- Priority rotation: after serving req2, req1 and req3 both valid. Expect req3 granted first, then req1.
- Backpressure: i_rsp_ready=0 for 5 cycles after o_rsp_valid rises (1.0+1.5 -> 0x4020). Expect data/id stable, o_req_ready all 0, o_busy=1. Expect the drain on the first edge with ready=1.
- ADD_LAT=2: model adder with a 2-cycle delay. Expect o_rsp_valid exactly 3 edges after acceptance with the correct sum, and no early capture.
- Reset in WAIT: assert i_rst_n=0 mid-WAIT. Expect all outputs at reset values immediately, no o_rsp_valid after release, and req0 granted first thereafter.

Source files
------------

// File: rtl/bf16_add_sched.sv
// Round-robin scheduler sharing one BF16 adder among NUM_REQ requesters.
// Latency: acceptance at edge E0 -> o_rsp_valid after edge E0+ADD_LAT+1; one op in flight.
// Backpressure: holds response in RESP until i_rsp_ready; no grants while WAIT/RESP.
module bf16_add_sched #(
  parameter int NUM_REQ   = 4,
  parameter int SIZE_DATA = 16,
  parameter int ADD_LAT   = 0,
  parameter int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [NUM_REQ-1:0]             i_req_valid,
  input  logic [NUM_REQ*SIZE_DATA-1:0]   i_req_a,
  input  logic [NUM_REQ*SIZE_DATA-1:0]   i_req_b,
  output logic [NUM_REQ-1:0]             o_req_ready,
  output logic [SIZE_DATA-1:0]           o_add_a,
  output logic [SIZE_DATA-1:0]           o_add_b,
  input  logic [SIZE_DATA-1:0]           i_add_result,
  output logic                           o_rsp_valid,
  output logic [SIZE_DATA-1:0]           o_rsp_data,
  output logic [ID_W-1:0]                o_rsp_id,
  input  logic                           i_rsp_ready,
  output logic                           o_busy
);

  // Counter must hold 0..ADD_LAT; keep at least one bit for the combinational-adder case.
  localparam int CNT_W = (ADD_LAT > 0) ? $clog2(ADD_LAT + 1) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e               state_q, state_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SIZE_DATA-1:0] add_a_q, add_a_d;
  logic [SIZE_DATA-1:0] add_b_q, add_b_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [SIZE_DATA-1:0] rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]      rsp_id_q, rsp_id_d;

  logic                 grant_vld;
  logic [ID_W-1:0]      grant_idx;
  logic [SIZE_DATA-1:0] sel_a, sel_b;

  // Round-robin search from ptr+1; walking offsets downward lets the nearest valid win.
  always_comb begin
    logic [ID_W-1:0] idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      idx = ID_W'((int'(ptr_q) + off) % NUM_REQ);
      if (i_req_valid[idx]) begin
        grant_vld = 1'b1;
        grant_idx = idx;
      end
    end
  end

  // Operand mux for the winning requester, using constant slices only.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_idx == ID_W'(k)) begin
        sel_a = i_req_a[k*SIZE_DATA +: SIZE_DATA];
        sel_b = i_req_b[k*SIZE_DATA +: SIZE_DATA];
      end
    end
  end

  // One-hot grant, only in IDLE and forced low while reset is asserted.
  always_comb begin
    o_req_ready = '0;
    if (state_q == IDLE && grant_vld && i_rst_n) begin
      o_req_ready[grant_idx] = 1'b1;
    end
  end

  // Next-state logic: accept in IDLE, count adder latency in WAIT, drain in RESP.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          add_a_d  = sel_a;
          add_b_d  = sel_b;
          rsp_id_d = grant_idx;
          ptr_d    = grant_idx;
          cnt_d    = '0;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        // The adder result is sampled exactly once, on the edge ending the last WAIT cycle.
        if (cnt_q == CNT_W'(ADD_LAT)) begin
          rsp_data_d  = i_add_result;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; ptr resets to the last requester so requester 0 has first priority.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= ID_W'(NUM_REQ - 1);
      cnt_q       <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign o_add_a     = add_a_q;
  assign o_add_b     = add_b_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_id    = rsp_id_q;
  assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_bf16_add_sched.sv
// Directed bench for bf16_add_sched: one instance with a combinational adder,
// one with a 2-cycle adder model. Inputs driven 1 time unit after rising edges,
// outputs checked there as well.
module tb_bf16_add_sched;

  logic clk;
  logic rst_n;

  // Instance with ADD_LAT = 0
  logic [3:0]  valid0;
  logic [63:0] req_a0, req_b0;
  logic [3:0]  ready0;
  logic [15:0] add_a0, add_b0, add_res0;
  logic        rsp_valid0;
  logic [15:0] rsp_data0;
  logic [1:0]  rsp_id0;
  logic        rsp_ready0;
  logic        busy0;

  // Instance with ADD_LAT = 2
  logic [3:0]  valid2;
  logic [63:0] req_a2, req_b2;
  logic [3:0]  ready2;
  logic [15:0] add_a2, add_b2;
  logic        rsp_valid2;
  logic [15:0] rsp_data2;
  logic [1:0]  rsp_id2;
  logic        rsp_ready2;
  logic        busy2;
  logic [15:0] pipe_s1 = 16'h0;
  logic [15:0] pipe_s2 = 16'h0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] rr_sum [0:3];

  // Hand-computed BF16 sums for the operand pairs this bench uses.
  function automatic logic [15:0] bf16_sum(input logic [15:0] a, input logic [15:0] b);
    case ({a, b})
      32'h3F80_4000: return 16'h4040; // 1.0 + 2.0 = 3.0
      32'h3F80_3FC0: return 16'h4020; // 1.0 + 1.5 = 2.5
      32'h3F80_3F80: return 16'h4000; // 1.0 + 1.0 = 2.0
      32'h4000_4000: return 16'h4080; // 2.0 + 2.0 = 4.0
      32'h4040_4040: return 16'h40C0; // 3.0 + 3.0 = 6.0
      default:       return 16'hDEAD;
    endcase
  endfunction

  assign add_res0 = bf16_sum(add_a0, add_b0);

  // Two-stage adder model: result valid two edges after the operand registers change.
  always @(posedge clk) begin
    pipe_s1 <= bf16_sum(add_a2, add_b2);
    pipe_s2 <= pipe_s1;
  end

  bf16_add_sched #(.NUM_REQ(4), .SIZE_DATA(16), .ADD_LAT(0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(valid0), .i_req_a(req_a0), .i_req_b(req_b0),
    .o_req_ready(ready0),
    .o_add_a(add_a0), .o_add_b(add_b0), .i_add_result(add_res0),
    .o_rsp_valid(rsp_valid0), .o_rsp_data(rsp_data0), .o_rsp_id(rsp_id0),
    .i_rsp_ready(rsp_ready0), .o_busy(busy0)
  );

  bf16_add_sched #(.NUM_REQ(4), .SIZE_DATA(16), .ADD_LAT(2)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(valid2), .i_req_a(req_a2), .i_req_b(req_b2),
    .o_req_ready(ready2),
    .o_add_a(add_a2), .o_add_b(add_b2), .i_add_result(pipe_s2),
    .o_rsp_valid(rsp_valid2), .o_rsp_data(rsp_data2), .o_rsp_id(rsp_id2),
    .i_rsp_ready(rsp_ready2), .o_busy(busy2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rr_sum[0] = 16'h4000;
    rr_sum[1] = 16'h4040;
    rr_sum[2] = 16'h4080;
    rr_sum[3] = 16'h40C0;

    // Reset values, with a request pending to show ready is forced low.
    rst_n      = 1'b0;
    valid0     = 4'b0001;
    req_a0     = '0;
    req_b0     = '0;
    rsp_ready0 = 1'b0;
    valid2     = 4'b0000;
    req_a2     = '0;
    req_b2     = '0;
    rsp_ready2 = 1'b0;
    #3;
    check("rst_ready", 32'(ready0), 32'h0);
    check("rst_busy", 32'(busy0), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid0), 32'h0);
    check("rst_add_a", 32'(add_a0), 32'h0);
    check("rst_add_b", 32'(add_b0), 32'h0);
    check("rst_rsp_data", 32'(rsp_data0), 32'h0);
    check("rst_rsp_id", 32'(rsp_id0), 32'h0);
    valid0 = 4'b0000;
    step();
    rst_n = 1'b1;

    // Single op, 1.0 + 2.0 on requester 0.
    req_a0 = {48'h0, 16'h3F80};
    req_b0 = {48'h0, 16'h4000};
    valid0 = 4'b0001;
    #1;
    check("t1_ready", 32'(ready0), 32'h1);
    step();
    valid0 = 4'b0000;
    check("t1_add_a", 32'(add_a0), 32'h3F80);
    check("t1_add_b", 32'(add_b0), 32'h4000);
    check("t1_busy", 32'(busy0), 32'h1);
    check("t1_ready_wait", 32'(ready0), 32'h0);
    check("t1_no_early_valid", 32'(rsp_valid0), 32'h0);
    step();
    check("t1_rsp_valid", 32'(rsp_valid0), 32'h1);
    check("t1_rsp_data", 32'(rsp_data0), 32'h4040);
    check("t1_rsp_id", 32'(rsp_id0), 32'h0);
    rsp_ready0 = 1'b1;
    step();
    check("t1_drained", 32'(rsp_valid0), 32'h0);
    check("t1_idle", 32'(busy0), 32'h0);

    // Fresh reset so requester 0 leads the round-robin sequence.
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;

    // Round-robin with all requesters valid, one response every 3 cycles.
    req_a0 = {16'h4040, 16'h4000, 16'h3F80, 16'h3F80};
    req_b0 = {16'h4040, 16'h4000, 16'h4000, 16'h3F80};
    valid0 = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("rr_ready%0d", k), 32'(ready0), 32'(1) << (k % 4));
      step();
      step();
      check($sformatf("rr_valid%0d", k), 32'(rsp_valid0), 32'h1);
      check($sformatf("rr_id%0d", k), 32'(rsp_id0), 32'(k % 4));
      check($sformatf("rr_data%0d", k), 32'(rsp_data0), 32'(rr_sum[k % 4]));
      step();
    end
    valid0 = 4'b0000;

    // Priority rotation: serve 2, then 3 beats 1.
    valid0 = 4'b0100;
    #1;
    check("pr_ready2", 32'(ready0), 32'h4);
    step();
    valid0 = 4'b0000;
    step();
    check("pr_id2", 32'(rsp_id0), 32'h2);
    step();
    valid0 = 4'b1010;
    #1;
    check("pr_ready3_first", 32'(ready0), 32'h8);
    step();
    valid0 = 4'b0010;
    step();
    check("pr_id3", 32'(rsp_id0), 32'h3);
    check("pr_data3", 32'(rsp_data0), 32'h40C0);
    step();
    check("pr_ready1", 32'(ready0), 32'h2);
    step();
    valid0 = 4'b0000;
    step();
    check("pr_id1", 32'(rsp_id0), 32'h1);
    check("pr_data1", 32'(rsp_data0), 32'h4040);
    step();

    // Backpressure: 1.0 + 1.5 held for 5 cycles with other requesters waiting.
    req_a0     = {16'h4040, 16'h4000, 16'h3F80, 16'h3F80};
    req_b0     = {16'h4040, 16'h4000, 16'h4000, 16'h3FC0};
    rsp_ready0 = 1'b0;
    valid0     = 4'b0001;
    #1;
    check("bp_ready0", 32'(ready0), 32'h1);
    step();
    valid0 = 4'b1110;
    step();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_valid%0d", i), 32'(rsp_valid0), 32'h1);
      check($sformatf("bp_data%0d", i), 32'(rsp_data0), 32'h4020);
      check($sformatf("bp_id%0d", i), 32'(rsp_id0), 32'h0);
      check($sformatf("bp_no_grant%0d", i), 32'(ready0), 32'h0);
      check($sformatf("bp_busy%0d", i), 32'(busy0), 32'h1);
      step();
    end
    rsp_ready0 = 1'b1;
    step();
    check("bp_drained", 32'(rsp_valid0), 32'h0);
    check("bp_idle", 32'(busy0), 32'h0);
    check("bp_regrant1", 32'(ready0), 32'h2);
    valid0 = 4'b0000;

    // Reset while in WAIT: op discarded, requester 0 first afterwards.
    valid0 = 4'b0100;
    #1;
    check("rw_ready2", 32'(ready0), 32'h4);
    step();
    valid0 = 4'b0000;
    check("rw_busy_wait", 32'(busy0), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("rw_busy", 32'(busy0), 32'h0);
    check("rw_add_a", 32'(add_a0), 32'h0);
    check("rw_rsp_valid", 32'(rsp_valid0), 32'h0);
    check("rw_rsp_data", 32'(rsp_data0), 32'h0);
    check("rw_ready", 32'(ready0), 32'h0);
    #1 rst_n = 1'b1;
    step();
    check("rw_no_rsp_a", 32'(rsp_valid0), 32'h0);
    step();
    check("rw_no_rsp_b", 32'(rsp_valid0), 32'h0);
    check("rw_idle", 32'(busy0), 32'h0);
    valid0 = 4'b1111;
    #1;
    check("rw_first_req0", 32'(ready0), 32'h1);
    valid0 = 4'b0000;

    // ADD_LAT = 2: response exactly 3 edges after acceptance, no early capture.
    req_a2 = {48'h0, 16'h3F80};
    req_b2 = {48'h0, 16'h4000};
    valid2 = 4'b0001;
    #1;
    check("l2_ready", 32'(ready2), 32'h1);
    step();
    valid2 = 4'b0000;
    check("l2_add_a", 32'(add_a2), 32'h3F80);
    step();
    check("l2_no_valid_e1", 32'(rsp_valid2), 32'h0);
    step();
    check("l2_no_valid_e2", 32'(rsp_valid2), 32'h0);
    check("l2_busy", 32'(busy2), 32'h1);
    step();
    check("l2_valid_e3", 32'(rsp_valid2), 32'h1);
    check("l2_data", 32'(rsp_data2), 32'h4040);
    check("l2_id", 32'(rsp_id2), 32'h0);
    rsp_ready2 = 1'b1;
    step();
    check("l2_drained", 32'(rsp_valid2), 32'h0);
    check("l2_idle", 32'(busy2), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
